uart_rx_fifo_apb: RTL and testbench
===================================

Name: uart_rx_fifo_apb

Overview:
Downstream stage of the UART receiver. Captures each byte the receiver completes (rx_done pulse plus rx_parallel) into a DEPTH-entry FIFO. Exposes the FIFO to the CPU as an APB slave with data, status and control registers. Raises a level interrupt when the FIFO reaches a programmable threshold or an overrun occurs.

Parameters:
DEPTH, 8, FIFO entries; power of two, 2..16
PTR_W, 3, log2(DEPTH)

Ports:
PCLK  in  1  system clock; all state on rising edge
PRESET  in  1  reset, asynchronous, active-high
PSEL  in  1  APB select
PENABLE  in  1  APB access phase
PWRITE  in  1  1 = write, 0 = read
PADDR  in  8  register address
PWDATA  in  8  write data
PRDATA  out  8  read data, registered
PREADY  out  1  transfer complete, registered
PSLVERR  out  1  error response, valid with PREADY
rx_done  in  1  byte-complete strobe from receiver
rx_parallel  in  8  received byte, valid while rx_done high
rx_irq  out  1  interrupt, registered level

Behaviour:
- Reset (async, PRESET=1): FIFO empty, pointers and count 0, overrun 0, CTRL 0, PRDATA 0, PREADY 0, PSLVERR 0, rx_irq 0, APB FSM in IDLE, rx_done history 0. Reset during an APB transfer aborts it; no PREADY is issued for that transfer.
- Push: on the first PCLK edge where rx_done=1 and the previous sample was 0 (rising-edge detect), write rx_parallel at wr_ptr. A held rx_done pushes once. Count is visible the next cycle.
- Full + push: byte dropped, FIFO unchanged, overrun sticky set.
- Register map (PADDR[7] must be 0):
  - 0x00 DATA (RO): read pops the head entry.
  - 0x01 STATUS (RO): [0] not_empty, [1] full, [2] overrun, [7:3] count. Reading STATUS clears overrun.
  - 0x02 CTRL (RW): [0] irq_en, [1] flush (write-1, self-clears, reads 0), [7:4] threshold; 0 means 1, values above DEPTH mean DEPTH.
  - Any other address: reads 0x00 with PSLVERR=1; writes are ignored with PSLVERR=1. Writes to DATA or STATUS: PSLVERR=1, no effect.
- APB FSM (one wait state on every transfer):
  - IDLE -> SETUP when PSEL=1, PENABLE=0.
  - SETUP -> ACCESS when PSEL=1, PENABLE=1.
  - ACCESS: perform the read/pop or write, register PRDATA/PSLVERR, drive PREADY=1 for exactly one cycle, then return to IDLE.
  - PSEL dropping before ACCESS returns the FSM to IDLE with no side effect.
  - PREADY=0 in all states except the single completion cycle. PSLVERR is 0 whenever PREADY is 0.
- DATA read while empty: PRDATA=0x00, PSLVERR=1, pointers unchanged.
- Simultaneous push and pop in one cycle: both occur, count unchanged. When full, a pop with a same-cycle push accepts the push with no overrun. The pop returns the old head.
- Flush vs push in the same cycle: flush wins and the incoming byte is discarded. Flush clears pointers, count and overrun.
- rx_irq is registered one cycle after its condition: irq_en & ((count >= effective threshold) | overrun).
- Pointers wrap modulo DEPTH. Count width is PTR_W+1 to distinguish full from empty.

Decomposition:
- Shared package: register offsets (DATA, STATUS, CTRL), STATUS/CTRL bit positions, and APB FSM state encoding (IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10).
- One natural sub-module: sync_fifo (DEPTH, width 8; push/pop/flush, full/empty/count). The APB decode and interrupt logic stay in the top module.

Test Plan:
1. Reset, then push 0xA5 via a one-cycle rx_done -> STATUS read returns 0x09 (count 1, not_empty). DATA read returns 0xA5 with PREADY after one wait state. STATUS then reads 0x00.
2. Push 9 bytes 0x01..0x09 with DEPTH=8 -> STATUS=0x47 (count 8, full, overrun). Eight DATA reads return 0x01..0x08. Second STATUS read shows overrun cleared.
3. DATA read on empty FIFO -> PRDATA=0x00, PSLVERR=1. Subsequent push/pop ordering is intact.
4. CTRL=0x31 (threshold 3, irq_en), push 3 bytes -> rx_irq rises one cycle after third push. One DATA read drops rx_irq one cycle after the pop.
5. Full FIFO, rx_done rising edge in the same cycle as a DATA ACCESS -> no overrun, count stays 8, read returns the oldest byte.
6. Assert PRESET mid-ACCESS with 4 bytes queued -> PREADY never asserts, STATUS=0x00 after release. Flush written together with a push -> count 0.

Source files
------------

// File: rtl/uart_rx_fifo_apb_pkg.sv
// Shared definitions for the UART receive FIFO APB block: register map, bit positions,
// APB FSM encoding and the interrupt threshold helper.
package uart_rx_fifo_apb_pkg;

  localparam logic [7:0] RegData   = 8'h00;
  localparam logic [7:0] RegStatus = 8'h01;
  localparam logic [7:0] RegCtrl   = 8'h02;

  localparam int unsigned StatNotEmpty = 0;
  localparam int unsigned StatFull     = 1;
  localparam int unsigned StatOverrun  = 2;
  localparam int unsigned StatCountLsb = 3;

  localparam int unsigned CtrlIrqEn  = 0;
  localparam int unsigned CtrlFlush  = 1;
  localparam int unsigned CtrlThrLsb = 4;

  typedef enum logic [1:0] {
    ApbIdle   = 2'b00,
    ApbSetup  = 2'b01,
    ApbAccess = 2'b10
  } apb_state_e;

  // A threshold of 0 behaves as 1; anything beyond the FIFO depth saturates at the depth.
  function automatic logic [4:0] eff_threshold(input logic [3:0] thr, input int unsigned depth);
    logic [4:0] res;
    if (thr == 4'd0) begin
      res = 5'd1;
    end else if ({28'd0, thr} > depth) begin
      res = 5'(depth);
    end else begin
      res = {1'b0, thr};
    end
    return res;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_apb_sync_fifo.sv
// Synchronous byte FIFO with push, pop and flush; flush overrides both push and pop.
module uart_rx_fifo_apb_sync_fifo #(
  parameter int unsigned Depth = 8,
  parameter int unsigned PtrW  = 3,
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [PtrW:0]    count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (PtrW+1)'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
  always_comb begin
    do_pop  = pop_i & ~empty_o & ~flush_i;
    do_push = push_i & (~full_o | do_pop) & ~flush_i;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (do_push && !do_pop) count_d = count_q + (PtrW+1)'(1);
      else if (!do_push && do_pop) count_d = count_q - (PtrW+1)'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_rx_fifo_apb.sv
// UART receive byte FIFO exposed as an APB slave (DATA/STATUS/CTRL) with a level interrupt
// on FIFO threshold or overrun.
module uart_rx_fifo_apb
  import uart_rx_fifo_apb_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = 3
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       PSEL,
  input  logic       PENABLE,
  input  logic       PWRITE,
  input  logic [7:0] PADDR,
  input  logic [7:0] PWDATA,
  output logic [7:0] PRDATA,
  output logic       PREADY,
  output logic       PSLVERR,
  input  logic       rx_done,
  input  logic [7:0] rx_parallel,
  output logic       rx_irq
);

  apb_state_e state_q, state_d;
  logic [7:0] prdata_q, prdata_d;
  logic       pready_q, pready_d;
  logic       pslverr_q, pslverr_d;
  logic       irq_en_q, irq_en_d;
  logic [3:0] thr_q, thr_d;
  logic       overrun_q, overrun_d;
  logic       rx_done_q;
  logic       rx_irq_q, rx_irq_d;

  logic       push_req, pop, flush, status_rd;
  logic       fifo_full, fifo_empty;
  logic [PTR_W:0] fifo_count;
  logic [7:0] fifo_rdata;
  logic [7:0] status_val, ctrl_val;
  logic       unused_pwdata;

  assign unused_pwdata = ^PWDATA[3:2];

  // Only the rising edge of rx_done counts, so a held strobe pushes once.
  assign push_req = rx_done & ~rx_done_q;

  uart_rx_fifo_apb_sync_fifo #(
    .Depth(DEPTH),
    .PtrW (PTR_W),
    .Width(8)
  ) u_fifo (
    .clk_i  (PCLK),
    .rst_i  (PRESET),
    .push_i (push_req),
    .wdata_i(rx_parallel),
    .pop_i  (pop),
    .flush_i(flush),
    .rdata_o(fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

  always_comb begin
    status_val                        = '0;
    status_val[StatNotEmpty]          = ~fifo_empty;
    status_val[StatFull]              = fifo_full;
    status_val[StatOverrun]           = overrun_q;
    status_val[7:StatCountLsb]        = 5'(fifo_count);
    ctrl_val                          = '0;
    ctrl_val[CtrlIrqEn]               = irq_en_q;
    ctrl_val[7:CtrlThrLsb]            = thr_q;
  end

  always_comb begin
    state_d   = state_q;
    prdata_d  = prdata_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    irq_en_d  = irq_en_q;
    thr_d     = thr_q;
    pop       = 1'b0;
    flush     = 1'b0;
    status_rd = 1'b0;

    unique case (state_q)
      ApbIdle: begin
        if (PSEL && !PENABLE) state_d = ApbSetup;
      end
      ApbSetup: begin
        if (!PSEL) state_d = ApbIdle;
        else if (PENABLE) state_d = ApbAccess;
      end
      ApbAccess: begin
        state_d  = ApbIdle;
        pready_d = 1'b1;
        prdata_d = '0;
        if (PWRITE) begin
          if (PADDR == RegCtrl) begin
            irq_en_d = PWDATA[CtrlIrqEn];
            thr_d    = PWDATA[7:CtrlThrLsb];
            flush    = PWDATA[CtrlFlush];
          end else begin
            pslverr_d = 1'b1;
          end
        end else begin
          case (PADDR)
            RegData: begin
              if (fifo_empty) begin
                pslverr_d = 1'b1;
              end else begin
                prdata_d = fifo_rdata;
                pop      = 1'b1;
              end
            end
            RegStatus: begin
              prdata_d  = status_val;
              status_rd = 1'b1;
            end
            RegCtrl:  prdata_d  = ctrl_val;
            default:  pslverr_d = 1'b1;
          endcase
        end
      end
      default: state_d = ApbIdle;
    endcase

    // A new overrun in the same cycle as a STATUS read stays visible for the next read.
    overrun_d = overrun_q;
    if (flush) overrun_d = 1'b0;
    else if (push_req && fifo_full && !pop) overrun_d = 1'b1;
    else if (status_rd) overrun_d = 1'b0;

    rx_irq_d = irq_en_q & ((5'(fifo_count) >= eff_threshold(thr_q, DEPTH)) | overrun_q);
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= ApbIdle;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      irq_en_q  <= 1'b0;
      thr_q     <= '0;
      overrun_q <= 1'b0;
      rx_done_q <= 1'b0;
      rx_irq_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      irq_en_q  <= irq_en_d;
      thr_q     <= thr_d;
      overrun_q <= overrun_d;
      rx_done_q <= rx_done;
      rx_irq_q  <= rx_irq_d;
    end
  end

  assign PRDATA  = prdata_q;
  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;
  assign rx_irq  = rx_irq_q;

endmodule

// File: tb/tb_uart_rx_fifo_apb.sv
// Bench for uart_rx_fifo_apb: directed APB/receiver stimulus, a queue-based reference model
// checked every cycle, and literal expectations for the key register reads.
module tb_uart_rx_fifo_apb;

  localparam int unsigned DEPTH = 8;

  logic       PCLK = 1'b0;
  logic       PRESET = 1'b1;
  logic       PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [7:0] PADDR = '0, PWDATA = '0;
  logic [7:0] PRDATA;
  logic       PREADY, PSLVERR;
  logic       rx_done = 1'b0;
  logic [7:0] rx_parallel = '0;
  logic       rx_irq;

  uart_rx_fifo_apb #(
    .DEPTH(8),
    .PTR_W(3)
  ) dut (
    .PCLK       (PCLK),
    .PRESET     (PRESET),
    .PSEL       (PSEL),
    .PENABLE    (PENABLE),
    .PWRITE     (PWRITE),
    .PADDR      (PADDR),
    .PWDATA     (PWDATA),
    .PRDATA     (PRDATA),
    .PREADY     (PREADY),
    .PSLVERR    (PSLVERR),
    .rx_done    (rx_done),
    .rx_parallel(rx_parallel),
    .rx_irq     (rx_irq)
  );

  always #5 PCLK = ~PCLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO as a queue plus the software-visible flags.
  logic [7:0] q[$];
  bit         m_ovr, m_irq_en, m_prev_rx;
  int         m_thr;
  logic       exp_ready = 1'b0, exp_err = 1'b0, exp_irq = 1'b0;
  logic [7:0] exp_rdata = '0;
  bit         acc_now = 1'b0, acc_write;
  logic [7:0] acc_addr, acc_wdata;

  task automatic model_step();
    logic [7:0] rd;
    bit err, pop, flush, st_rd, push, ovf, nirq;
    int et;
    et   = (m_thr == 0) ? 1 : ((m_thr > DEPTH) ? DEPTH : m_thr);
    nirq = m_irq_en && ((q.size() >= et) || m_ovr);
    push = rx_done && !m_prev_rx;
    m_prev_rx = rx_done;
    pop = 0; flush = 0; st_rd = 0;
    exp_ready = 1'b0;
    exp_err   = 1'b0;
    if (acc_now) begin
      acc_now = 0;
      exp_ready = 1'b1;
      rd = 8'h00;
      err = 0;
      if (acc_write) begin
        if (acc_addr == 8'h02) begin
          m_irq_en = acc_wdata[0];
          m_thr    = int'(acc_wdata[7:4]);
          flush    = acc_wdata[1];
        end else begin
          err = 1;
        end
      end else begin
        case (acc_addr)
          8'h00: if (q.size() != 0) begin rd = q[0]; pop = 1; end else err = 1;
          8'h01: begin
            rd = {5'(q.size()), m_ovr, q.size() == DEPTH, q.size() != 0};
            st_rd = 1;
          end
          8'h02: rd = {4'(m_thr), 3'b000, m_irq_en};
          default: err = 1;
        endcase
      end
      exp_rdata = rd;
      exp_err   = err;
    end
    if (flush) begin
      q.delete();
      m_ovr = 0;
    end else begin
      if (pop) void'(q.pop_front());
      ovf = push && (q.size() >= DEPTH);
      if (push && !ovf) q.push_back(rx_parallel);
      if (ovf) m_ovr = 1;
      else if (st_rd) m_ovr = 0;
    end
    exp_irq = nirq;
  endtask

  initial begin
    forever begin
      @(posedge PCLK or posedge PRESET);
      if (PRESET) begin
        q.delete();
        m_ovr = 0; m_irq_en = 0; m_prev_rx = 0; m_thr = 0;
        exp_ready = 1'b0; exp_err = 1'b0; exp_irq = 1'b0; exp_rdata = '0;
        acc_now = 0;
      end else begin
        model_step();
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge PCLK);
      chk("PREADY", PREADY, exp_ready);
      chk("rx_irq", rx_irq, exp_irq);
      if (exp_ready) begin
        chk("PRDATA", PRDATA, exp_rdata);
        chk("PSLVERR", PSLVERR, exp_err);
      end else begin
        chk("PSLVERR idle", PSLVERR, 1'b0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic apb(input bit wr, input logic [7:0] addr, input logic [7:0] wdata,
                     input bit with_push, input logic [7:0] pbyte,
                     output logic [7:0] rdata, output logic err);
    int n;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    acc_write = wr; acc_addr = addr; acc_wdata = wdata; acc_now = 1;
    if (with_push) begin
      rx_parallel = pbyte;
      rx_done = 1'b1;
    end
    n = 0;
    do begin
      @(negedge PCLK);
      n++;
    end while (PREADY !== 1'b1 && n < 4);
    rdata = PRDATA;
    err   = PSLVERR;
    if (PREADY !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL apb timeout addr 0x%02h: PREADY got %b expected 1", addr, PREADY);
    end
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; rx_done = 1'b0;
  endtask

  task automatic read_chk(input string name, input logic [7:0] addr,
                          input logic [7:0] exp_d, input logic exp_e);
    logic [7:0] d;
    logic e;
    apb(1'b0, addr, 8'h00, 1'b0, 8'h00, d, e);
    chk({name, " data"}, d, exp_d);
    chk({name, " err"}, e, exp_e);
  endtask

  task automatic write_chk(input string name, input logic [7:0] addr, input logic [7:0] data,
                           input bit with_push, input logic [7:0] pbyte, input logic exp_e);
    logic [7:0] d;
    logic e;
    apb(1'b1, addr, data, with_push, pbyte, d, e);
    chk({name, " err"}, e, exp_e);
  endtask

  task automatic push(input logic [7:0] b);
    rx_parallel = b;
    rx_done = 1'b1;
    @(posedge PCLK); #1;
    rx_done = 1'b0;
    @(posedge PCLK); #1;
  endtask

  initial begin
    logic [7:0] d;
    logic e;
    @(negedge PCLK);
    chk("reset PREADY", PREADY, 1'b0);
    chk("reset PRDATA", PRDATA, 8'h00);
    chk("reset rx_irq", rx_irq, 1'b0);
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    @(posedge PCLK); #1;
    read_chk("reset STATUS", 8'h01, 8'h00, 1'b0);
    read_chk("reset CTRL", 8'h02, 8'h00, 1'b0);

    // 1: single byte round trip
    push(8'hA5);
    read_chk("t1 STATUS", 8'h01, 8'h09, 1'b0);
    read_chk("t1 DATA", 8'h00, 8'hA5, 1'b0);
    read_chk("t1 STATUS after", 8'h01, 8'h00, 1'b0);

    // 2: overflow, then drain
    for (int i = 1; i <= 9; i++) push(8'(i));
    read_chk("t2 STATUS ovr", 8'h01, 8'h47, 1'b0);
    read_chk("t2 STATUS cleared", 8'h01, 8'h43, 1'b0);
    for (int i = 1; i <= 8; i++) read_chk("t2 DATA", 8'h00, 8'(i), 1'b0);
    read_chk("t2 STATUS empty", 8'h01, 8'h00, 1'b0);

    // 3: empty read and bad accesses, then ordering
    read_chk("t3 empty DATA", 8'h00, 8'h00, 1'b1);
    read_chk("t3 bad addr", 8'h05, 8'h00, 1'b1);
    read_chk("t3 addr bit7", 8'h82, 8'h00, 1'b1);
    write_chk("t3 write DATA", 8'h00, 8'hFF, 1'b0, 8'h00, 1'b1);
    write_chk("t3 write STATUS", 8'h01, 8'hFF, 1'b0, 8'h00, 1'b1);
    push(8'h11);
    push(8'h22);
    read_chk("t3 DATA first", 8'h00, 8'h11, 1'b0);
    read_chk("t3 DATA second", 8'h00, 8'h22, 1'b0);

    // 4: threshold interrupt
    write_chk("t4 CTRL", 8'h02, 8'h33, 1'b0, 8'h00, 1'b0);
    read_chk("t4 CTRL readback", 8'h02, 8'h31, 1'b0);
    push(8'h31);
    push(8'h32);
    chk("t4 irq below thr", rx_irq, 1'b0);
    push(8'h33);
    chk("t4 irq at thr", rx_irq, 1'b1);
    read_chk("t4 DATA", 8'h00, 8'h31, 1'b0);
    chk("t4 irq after pop", rx_irq, 1'b0);
    write_chk("t4 CTRL thr0", 8'h02, 8'h01, 1'b0, 8'h00, 1'b0);
    chk("t4 irq thr0 means 1", rx_irq, 1'b1);
    write_chk("t4 CTRL thr15", 8'h02, 8'hF1, 1'b0, 8'h00, 1'b0);
    chk("t4 irq thr saturates", rx_irq, 1'b0);

    // 5: full FIFO, push in the same cycle as a pop
    write_chk("t5 flush", 8'h02, 8'h02, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) push(8'(8'h80 + i));
    apb(1'b0, 8'h00, 8'h00, 1'b1, 8'h88, d, e);
    chk("t5 DATA oldest", d, 8'h80);
    chk("t5 DATA err", e, 1'b0);
    read_chk("t5 STATUS", 8'h01, 8'h43, 1'b0);

    // 6: reset during ACCESS, then flush racing a push
    write_chk("t6 flush", 8'h02, 8'h02, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) push(8'(8'hC0 + i));
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'h00;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PRESET = 1'b1;
    repeat (3) begin
      @(negedge PCLK);
      chk("t6 PREADY in reset", PREADY, 1'b0);
    end
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PRESET = 1'b0;
    repeat (2) begin
      @(negedge PCLK);
      chk("t6 PREADY after reset", PREADY, 1'b0);
    end
    @(posedge PCLK); #1;
    read_chk("t6 STATUS", 8'h01, 8'h00, 1'b0);
    push(8'h55);
    read_chk("t6 STATUS one", 8'h01, 8'h09, 1'b0);
    write_chk("t6 flush+push", 8'h02, 8'h02, 1'b1, 8'h66, 1'b0);
    read_chk("t6 STATUS flushed", 8'h01, 8'h00, 1'b0);

    repeat (3) @(posedge PCLK);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
